uop_queue: RTL and testbench
============================

// Module: uop_queue
// PURPOSE
//  Decoupling FIFO between the ucode/decode stage (uc0) and rename (rn0).
//  Accepts one uop/cycle from ucode and presents one uop/cycle to rename, in order.
//  Its registered ready drives ucode's rename_ready_rn0 input, so rename backpressure
//  no longer feeds combinationally into the ucode FSM.
//  Flushes completely on nuke or branch mispredict.
// PARAMETERS
//  DEPTH   8   entry count; power of 2, >=2
// PORTS
//  clk               in   1            clock
//  reset_n           in   1            async active-low reset
//  nuke_rb1          in   t_nuke_pkt   nuke; .valid flushes queue
//  br_mispred_ex0    in   t_br_mispred_pkt  mispredict; .valid flushes queue
//  valid_uc0         in   1            uop offered by ucode
//  uinstr_uc0        in   t_uinstr     uop payload
//  uopq_ready_uc0    out  1            queue can accept this cycle (to ucode rename_ready_rn0)
//  valid_rn0         out  1            head uop valid to rename
//  uinstr_rn0        out  t_uinstr     head uop payload
//  rename_ready_rn0  in   1            rename consumes head this cycle
//  uopq_count        out  $clog2(DEPTH)+1  current occupancy
//  uopq_empty        out  1            occupancy == 0
// BEHAVIOUR
//  Reset: async on reset_n low.
//    rd/wr ptr=0, count=0, uopq_ready_uc0=0, valid_rn0=0, uopq_empty=1.
//    Storage is not reset.
//  First rising clk after reset_n high: uopq_ready_uc0 goes 1.
//  Pointers: $clog2(DEPTH)+1 bits with wrap bit.
//    Index = low bits; full = idx equal and wrap differs; empty = ptrs equal.
//  enq  = valid_uc0 & uopq_ready_uc0 & ~flush.
//    Writes entry[wr]; wr+1.
//  deq  = valid_rn0 & rename_ready_rn0.
//    rd+1; storage is a ring, so a pointer passing DEPTH-1 wraps to 0.
//  flush = nuke_rb1.valid | br_mispred_ex0.valid.
//    Every queued uop is pre-rename and therefore younger than any ROB entry,
//    so flush discards ALL entries.
//    Next cycle: rd=wr=0, count=0.
//    Flush beats enq and deq in the same cycle; the uop offered is dropped.
//  valid_rn0  = ~empty & ~flush.
//    The combinational flush mask stops a doomed uop reaching rename in the flush cycle.
//  uinstr_rn0 = entry[rd], driven directly from storage (no output register).
//  Latency: a uop enqueued at cycle N is visible at valid_rn0 at N+1 at the earliest.
//    No same-cycle bypass.
//  count_nxt = flush ? 0 : count + enq - deq.
//    Simultaneous enq and deq leaves count unchanged.
//  uopq_ready_uc0 is a register, loaded with (count_nxt < DEPTH) & ~flush.
//    Flush cycle: ready=0 in the following cycle; it returns to 1 one cycle later.
//    Full: ready=0. A deq at cycle N raises ready at N+1; the freed slot is not
//    reusable in cycle N.
//  Because ready is registered from count_nxt, enqueue into a full queue is impossible.
//  uopq_count and uopq_empty are registered copies of the count state.
//  Assertions (ASSERT):
//    - no enq when full;
//    - no deq when empty;
//    - count equals the pointer difference;
//    - uinstr_rn0 is stable while valid_rn0 & ~rename_ready_rn0 & ~flush.
//  SIMULATION: UINFO logs "unit:UQ func:enq" / "func:deq" with the SIMID.
// TESTING
//  1. Release reset_n; ready=0 in the release cycle, 1 next clk; count=0, valid_rn0=0.
//  2. Enq 3 uops A,B,C on back-to-back cycles with rename_ready=1.
//     -> valid_rn0 from the cycle after A; A,B,C delivered in order, one per cycle;
//        count peaks at 1.
//  3. rename_ready=0, offer 10 uops with DEPTH=8.
//     -> 8 accepted, count=8, ready=0; raise rename_ready for 1 cycle
//        -> ready=1 next cycle, 9th uop accepted.
//  4. Queue holds 5; pulse br_mispred_ex0.valid with valid_uc0=1.
//     -> valid_rn0=0 that cycle, offered uop dropped; next cycle count=0,
//        empty=1, ready=0; ready=1 the cycle after.
//  5. Same as 4 using nuke_rb1.valid, with rename_ready=1 in the flush cycle
//     -> no deq handshake occurs; queue empty.
//  6. Push/pop 20 uops with rename_ready random ~50%.
//     -> pointers wrap past 7; output order equals input order; no assertion fires.
//  7. Assert reset_n low mid-stream with count=4.
//     -> outputs go to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/uop_queue_if.sv
// Handshake bundle between ucode (uc0), the uop queue and rename (rn0).
// The slave modport is the queue side; master is the ucode/rename/flush environment.
interface uop_queue_if #(
    parameter int DEPTH = 8,
    parameter int W     = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    struct packed { logic valid; } nuke_rb1;
    struct packed { logic valid; } br_mispred_ex0;

    logic         valid_uc0;
    logic [W-1:0] uinstr_uc0;
    logic         uopq_ready_uc0;
    logic         valid_rn0;
    logic [W-1:0] uinstr_rn0;
    logic         rename_ready_rn0;
    logic [CW-1:0] uopq_count;
    logic         uopq_empty;

    modport slave (
        input  nuke_rb1, br_mispred_ex0,
        input  valid_uc0, uinstr_uc0, rename_ready_rn0,
        output uopq_ready_uc0, valid_rn0, uinstr_rn0, uopq_count, uopq_empty
    );

    modport master (
        output nuke_rb1, br_mispred_ex0,
        output valid_uc0, uinstr_uc0, rename_ready_rn0,
        input  uopq_ready_uc0, valid_rn0, uinstr_rn0, uopq_count, uopq_empty
    );
endinterface

// File: rtl/uop_queue.sv
// In-order decoupling FIFO between ucode and rename with a registered ready
// and a full flush on nuke or branch mispredict.
module uop_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    uop_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] count_reg, count_next;
    logic          ready_reg, ready_next;
    logic          empty_reg, empty_next;

    logic flush;
    logic enq;
    logic deq;
    logic ptr_empty;
    logic full;
    logic valid_out;

    always_comb begin
        flush     = q.nuke_rb1.valid | q.br_mispred_ex0.valid;
        ptr_empty = (wr_ptr_reg == rd_ptr_reg);
        full      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                    (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
        // Mask the head in the flush cycle so a doomed uop never reaches rename.
        valid_out = ~ptr_empty & ~flush;
        enq       = q.valid_uc0 & ready_reg & ~flush;
        deq       = valid_out & q.rename_ready_rn0;
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            wr_ptr_next = wr_ptr_reg + PW'(enq);
            rd_ptr_next = rd_ptr_reg + PW'(deq);
            count_next  = count_reg + PW'(enq) - PW'(deq);
        end
        // Ready looks at next occupancy, so a full queue can never be written.
        ready_next = ~flush && (count_next < PW'(DEPTH));
        empty_next = (count_next == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ready_reg  <= ready_next;
            empty_reg  <= empty_next;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_reg[AW-1:0]] <= q.uinstr_uc0;
        end
    end

    assign q.uopq_ready_uc0 = ready_reg;
    assign q.valid_rn0      = valid_out;
    assign q.uinstr_rn0     = mem[rd_ptr_reg[AW-1:0]];
    assign q.uopq_count     = count_reg;
    assign q.uopq_empty     = empty_reg;

    a_no_enq_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(enq && full));
    a_no_deq_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(deq && ptr_empty));
    a_count_ptrs: assert property (@(posedge clk) disable iff (!reset_n)
        count_reg == PW'(wr_ptr_reg - rd_ptr_reg));
    a_head_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (valid_out && !q.rename_ready_rn0 && !flush) |=> $stable(q.uinstr_rn0));
endmodule

// File: tb/tb_uop_queue.sv
// Randomized bench for uop_queue: a queue-based reference model checked every
// cycle, plus directed sequences pinned with literal expectations.
module tb_uop_queue;
    localparam int DEPTH = 8;
    localparam int W     = 32;

    logic clk;
    logic reset_n;

    uop_queue_if #(.DEPTH(DEPTH), .W(W)) q ();

    uop_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] mq[$];
    logic         m_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: an ordered list of uops plus the ready flag seen by ucode.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ready <= 1'b0;
        end else if (q.nuke_rb1.valid || q.br_mispred_ex0.valid) begin
            mq.delete();
            m_ready <= 1'b0;
        end else begin
            if (mq.size() != 0 && q.rename_ready_rn0) void'(mq.pop_front());
            if (q.valid_uc0 && m_ready) mq.push_back(q.uinstr_uc0);
            m_ready <= (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        logic fl;
        logic exp_valid;
        fl        = q.nuke_rb1.valid | q.br_mispred_ex0.valid;
        exp_valid = (mq.size() != 0) && !fl;
        chk("ready", 64'(q.uopq_ready_uc0), 64'(m_ready));
        chk("count", 64'(q.uopq_count), 64'(mq.size()));
        chk("empty", 64'(q.uopq_empty), 64'(mq.size() == 0));
        chk("valid_rn0", 64'(q.valid_rn0), 64'(exp_valid));
        if (exp_valid) chk("uinstr_rn0", 64'(q.uinstr_rn0), 64'(mq[0]));
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic rr,
                        input logic nk, input logic br);
        @(posedge clk);
        #1;
        q.valid_uc0            = v;
        q.uinstr_uc0           = d;
        q.rename_ready_rn0     = rr;
        q.nuke_rb1.valid       = nk;
        q.br_mispred_ex0.valid = br;
    endtask

    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    task automatic drain;
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int peak;
        int acc;
        reset_n                = 1'b0;
        q.valid_uc0            = 1'b0;
        q.uinstr_uc0           = '0;
        q.rename_ready_rn0     = 1'b0;
        q.nuke_rb1.valid       = 1'b0;
        q.br_mispred_ex0.valid = 1'b0;
        repeat (3) @(posedge clk);

        // Reset release: ready stays low in the release cycle, rises one clock later.
        #1 reset_n = 1'b1;
        mid();
        chk("lit_ready_release", 64'(q.uopq_ready_uc0), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("lit_ready_after", 64'(q.uopq_ready_uc0), 64'd1);
        chk("lit_count_after", 64'(q.uopq_count), 64'd0);
        chk("lit_valid_after", 64'(q.valid_rn0), 64'd0);

        // Three back-to-back uops with rename always ready.
        peak = 0;
        step(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
        mid();
        chk("lit_no_bypass", 64'(q.valid_rn0), 64'd0);
        step(1'b1, 32'hB, 1'b1, 1'b0, 1'b0);
        mid();
        chk("lit_head_a", 64'(q.uinstr_rn0), 64'hA);
        if (int'(q.uopq_count) > peak) peak = int'(q.uopq_count);
        step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        mid();
        chk("lit_head_b", 64'(q.uinstr_rn0), 64'hB);
        if (int'(q.uopq_count) > peak) peak = int'(q.uopq_count);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        mid();
        chk("lit_head_c", 64'(q.uinstr_rn0), 64'hC);
        if (int'(q.uopq_count) > peak) peak = int'(q.uopq_count);
        chk("lit_peak", 64'(peak), 64'd1);
        drain();

        // Fill to full with rename stalled, then free one slot.
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        mid();
        chk("lit_full_count", 64'(q.uopq_count), 64'd8);
        chk("lit_full_ready", 64'(q.uopq_ready_uc0), 64'd0);
        step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        mid();
        chk("lit_deq_ready_same", 64'(q.uopq_ready_uc0), 64'd0);
        step(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        mid();
        chk("lit_deq_ready_next", 64'(q.uopq_ready_uc0), 64'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("lit_ninth_count", 64'(q.uopq_count), 64'd8);
        drain();

        // Mispredict flush with a uop offered in the flush cycle.
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        mid();
        chk("lit_br_valid", 64'(q.valid_rn0), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("lit_br_count", 64'(q.uopq_count), 64'd0);
        chk("lit_br_empty", 64'(q.uopq_empty), 64'd1);
        chk("lit_br_ready0", 64'(q.uopq_ready_uc0), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("lit_br_ready1", 64'(q.uopq_ready_uc0), 64'd1);

        // Nuke flush with rename ready in the flush cycle.
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        mid();
        chk("lit_nuke_valid", 64'(q.valid_rn0), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        mid();
        chk("lit_nuke_count", 64'(q.uopq_count), 64'd0);
        chk("lit_nuke_valid2", 64'(q.valid_rn0), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Twenty uops with random rename backpressure; pointers wrap.
        acc = 0;
        for (int i = 0; i < 200 && acc < 20; i++) begin
            step(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (m_ready) acc++;
        end
        chk("lit_twenty_accepted", 64'(acc), 64'd20);
        drain();

        // Fully random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 39) == 0));
        end
        drain();

        // Asynchronous reset with four entries queued.
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        mid();
        chk("lit_pre_reset_count", 64'(q.uopq_count), 64'd4);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("lit_areset_count", 64'(q.uopq_count), 64'd0);
        chk("lit_areset_valid", 64'(q.valid_rn0), 64'd0);
        chk("lit_areset_empty", 64'(q.uopq_empty), 64'd1);
        chk("lit_areset_ready", 64'(q.uopq_ready_uc0), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        drain();
        mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
